dco_multi: RTL and testbench

- Multi-channel, parametrised digitally controlled oscillator. Generates NUM_CH independent square waves from the single system clock.
- Each channel has a programmable half-period count. A shared prescaler sets the tick rate.
- Period updates use a valid/ready handshake and are shadow-loaded, so they take effect only at a toggle boundary. Output is glitch-free.
- Sits between the control registers (code source) and the top-level output pins.

---
 rtl/dco_multi_if.sv | 34 +++
 rtl/dco_multi.sv | 171 +++++++++++++++++
 tb/tb_dco_multi.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dco_multi_if.sv
// dco_multi_if -- half-period code request channel for dco_multi.
//
// Signals:
//   code_valid  request present
//   code_ch     target channel, max(1, $clog2(NUM_CH)) bits
//   code        requested half-period count, CNT_W bits
//   code_ready  request can be accepted this cycle
//
// Modports: master (code source), slave (dco_multi).
interface dco_multi_if #(
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             code_valid;
    logic [CH_W-1:0]  code_ch;
    logic [CNT_W-1:0] code;
    logic             code_ready;

    modport master (
        output code_valid,
        output code_ch,
        output code,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code_ch,
        input  code,
        output code_ready
    );
endinterface

// File: rtl/dco_multi.sv
// dco_multi -- multi-channel digitally controlled oscillator.
//
// Generates NUM_CH independent square waves from clk. A shared prescaler
// produces a tick every presc+1 enabled clocks; each channel counts ticks up
// to its active half-period H and toggles its output when the count hits H.
// New half-period codes arrive over a valid/ready channel, are held in a
// per-channel shadow register and only take effect at that channel's next
// toggle boundary, so the output never glitches.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   en            global enable; low freezes prescaler, counters, outputs
//   presc         prescaler divide value (tick period = presc+1 clk)
//   sync          phase-align pulse (only with DCO_PHASE_SYNC_EN defined)
//   code_if       code request channel (slave modport)
//   dco_out       oscillator outputs
//   toggle_pulse  one-clk strobe per channel when dco_out changes
//   pending       shadow register holds an unapplied code
//
// Optional feature macro: DCO_PHASE_SYNC_EN adds the sync input, which
// clears all counters and outputs and applies pending shadows at once.
module dco_multi #(
    parameter int CNT_W   = 8,
    parameter int NUM_CH  = 2,
    parameter int PRESC_W = 4,
    parameter int RST_HP  = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
`ifdef DCO_PHASE_SYNC_EN
    input  logic               sync,
`endif
    dco_multi_if.slave         code_if,
    output logic [NUM_CH-1:0]  dco_out,
    output logic [NUM_CH-1:0]  toggle_pulse,
    output logic [NUM_CH-1:0]  pending
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_SPAN = 2 ** CH_W;

    logic               sync_now;
    logic [PRESC_W-1:0] pc;
    logic               tick;
    logic               accept;
    logic [CH_SPAN-1:0] pend_ext;

`ifdef DCO_PHASE_SYNC_EN
    always_comb sync_now = sync;
`else
    always_comb sync_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Prescaler. The >= compare means lowering presc below the current
    // count produces a tick immediately instead of wrapping the counter.
    // ------------------------------------------------------------------
    always_comb tick = en && (pc >= presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (sync_now || tick) begin
            pc <= '0;
        end else if (en) begin
            pc <= pc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake. Channel indices beyond NUM_CH (only reachable when NUM_CH
    // is not a power of two) read as never-pending, so such requests are
    // accepted and match no channel.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < CH_SPAN; g++) begin : g_pend
        if (g < NUM_CH) begin : g_in
            always_comb pend_ext[g] = pending[g];
        end else begin : g_out
            always_comb pend_ext[g] = 1'b0;
        end
    end

    always_comb code_if.code_ready = !pend_ext[code_if.code_ch];
    always_comb accept             = code_if.code_valid && code_if.code_ready;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_nx;
        logic [CNT_W-1:0] hp_q, hp_nx;
        logic [CNT_W-1:0] sh_q, sh_nx;
        logic             pend_q, pend_nx;
        logic             dco_q, dco_nx;
        logic             tp_q;
        logic             acc_ch;
        logic             bnd;

        always_comb acc_ch = accept && (code_if.code_ch == CH_W'(g));

        // A stopped channel (H=0) treats every tick as a boundary so that
        // a queued code can restart it on the very next tick.
        always_comb bnd = tick && ((hp_q == '0) || (cnt_q == hp_q));

        always_comb begin
            cnt_nx  = cnt_q;
            hp_nx   = hp_q;
            sh_nx   = sh_q;
            pend_nx = pend_q;
            dco_nx  = dco_q;

            if (sync_now) begin
                cnt_nx = '0;
                dco_nx = 1'b0;
                if (pend_q) begin
                    hp_nx   = sh_q;
                    pend_nx = 1'b0;
                end
            end else if (bnd) begin
                cnt_nx = '0;
                if (pend_q) begin
                    hp_nx   = sh_q;
                    pend_nx = 1'b0;
                end
                // The toggle is decided by the old H: a stopped channel
                // restarting does not toggle, a running one does unless the
                // new code stops it, in which case the output is parked low.
                if (pend_q && (sh_q == '0)) begin
                    dco_nx = 1'b0;
                end else if (hp_q != '0) begin
                    dco_nx = !dco_q;
                end
            end else if (tick) begin
                cnt_nx = cnt_q + 1'b1;
            end

            // pend_q is still clear on the accept cycle, so a same-cycle
            // boundary above used the old H and this code waits.
            if (acc_ch) begin
                sh_nx   = code_if.code;
                pend_nx = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                hp_q   <= CNT_W'(RST_HP);
                sh_q   <= '0;
                pend_q <= 1'b0;
                dco_q  <= 1'b0;
                tp_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_nx;
                hp_q   <= hp_nx;
                sh_q   <= sh_nx;
                pend_q <= pend_nx;
                dco_q  <= dco_nx;
                tp_q   <= (dco_nx != dco_q);
            end
        end

        always_comb dco_out[g]      = dco_q;
        always_comb toggle_pulse[g] = tp_q;
        always_comb pending[g]      = pend_q;
    end

endmodule

// File: tb/tb_dco_multi.sv
// tb_dco_multi -- self-checking bench for dco_multi (NUM_CH=2 main DUT plus
// a NUM_CH=3 instance for out-of-range channel requests).
//
// Expected toggle events (edge number after reset release and new level) are
// queued per channel when a scenario is set up; a monitor pops and compares
// them whenever toggle_pulse is seen. Sync scenarios are compiled in when
// DCO_PHASE_SYNC_EN is defined.
module tb_dco_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] presc = '0;
`ifdef DCO_PHASE_SYNC_EN
    logic       sync = 1'b0;
`endif
    logic [1:0] dco_out, toggle_pulse, pending;
    logic [2:0] dco3, tp3, pend3;

    dco_multi_if #(.CNT_W(8), .NUM_CH(2)) bus  ();
    dco_multi_if #(.CNT_W(8), .NUM_CH(3)) bus3 ();

    dco_multi #(.CNT_W(8), .NUM_CH(2), .PRESC_W(4), .RST_HP(50)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .presc        (presc),
`ifdef DCO_PHASE_SYNC_EN
        .sync         (sync),
`endif
        .code_if      (bus),
        .dco_out      (dco_out),
        .toggle_pulse (toggle_pulse),
        .pending      (pending)
    );

    dco_multi #(.CNT_W(8), .NUM_CH(3), .PRESC_W(4), .RST_HP(50)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .presc        (presc),
`ifdef DCO_PHASE_SYNC_EN
        .sync         (1'b0),
`endif
        .code_if      (bus3),
        .dco_out      (dco3),
        .toggle_pulse (tp3),
        .pending      (pend3)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release.
    int ecount;
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    typedef struct {
        int cyc;
        int lvl;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    task automatic expect_ev(input int c, input int cyc, input int lvl);
        ev_t e;
        e.cyc = cyc;
        e.lvl = lvl;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_check(input int c);
        ev_t e;
        if (c == 0) begin
            check("ch0_pulse_expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("ch0_toggle_edge", ecount, e.cyc);
                check("ch0_toggle_level", 32'(dco_out[0]), e.lvl);
            end
        end else begin
            check("ch1_pulse_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("ch1_toggle_edge", ecount, e.cyc);
                check("ch1_toggle_level", 32'(dco_out[1]), e.lvl);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (toggle_pulse[0]) pop_check(0);
            if (toggle_pulse[1]) pop_check(1);
        end
    end

    task automatic run_to(input int n);
        while (ecount < n) @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_dco_out", 32'(dco_out), 32'd0);
        check("rst_toggle_pulse", 32'(toggle_pulse), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_code_ready", 32'(bus.code_ready), 32'd1);
        q0.delete();
        q1.delete();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic end_phase(input int horizon);
        run_to(horizon);
        #1;
        check("ch0_missing_toggles", q0.size(), 32'd0);
        check("ch1_missing_toggles", q1.size(), 32'd0);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.code_valid  = 1'b0;
        bus.code_ch     = '0;
        bus.code        = '0;
        bus3.code_valid = 1'b0;
        bus3.code_ch    = '0;
        bus3.code       = '0;
        en    = 1'b1;
        presc = 4'd0;

        // ---- Reset period, then ch0 reloaded to H=3 mid half-period ----
        do_reset();
        expect_ev(0, 51, 1);
        expect_ev(0, 102, 0);
        for (int t = 106, l = 1; t <= 160; t += 4, l = 1 - l) expect_ev(0, t, l);
        expect_ev(1, 51, 1);
        expect_ev(1, 102, 0);
        expect_ev(1, 153, 1);
        release_rst();
        run_to(50);
        check("pre_first_rise", 32'(dco_out), 32'd0);
        run_to(51);
        check("first_rise", 32'(dco_out), 32'd3);
        run_to(60);
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b0;
        bus.code       = 8'd3;
        #1;
        check("ready_idle_ch0", 32'(bus.code_ready), 32'd1);
        run_to(61);
        bus.code_valid = 1'b0;
        #1;
        check("pending_after_load", 32'(pending), 32'd1);
        check("ready_blocked_ch0", 32'(bus.code_ready), 32'd0);
        run_to(101);
        check("pending_before_bnd", 32'(pending), 32'd1);
        run_to(102);
        check("pending_cleared", 32'(pending), 32'd0);
        check("ready_after_bnd", 32'(bus.code_ready), 32'd1);
        end_phase(160);

        // ---- presc=3, H=1, en dropped for 5 clk ----
        do_reset();
        expect_ev(0, 51, 1);
        expect_ev(0, 59, 0);
        expect_ev(0, 67, 1);
        expect_ev(0, 80, 0);
        expect_ev(0, 88, 1);
        expect_ev(0, 96, 0);
        expect_ev(0, 104, 1);
        expect_ev(1, 51, 1);
        presc          = 4'd0;
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b0;
        bus.code       = 8'd1;
        release_rst();
        run_to(1);
        bus.code_valid = 1'b0;
        run_to(51);
        presc = 4'd3;
        run_to(70);
        en = 1'b0;
        run_to(73);
        check("hold_while_disabled", 32'(dco_out[0]), 32'd1);
        run_to(75);
        en = 1'b1;
        end_phase(110);

        // ---- ch1 stopped with H=0 then restarted with H=2; ch0 same-cycle
        //      accept and boundary ----
        do_reset();
        presc = 4'd0;
        expect_ev(0, 51, 1);
        expect_ev(0, 102, 0);
        expect_ev(0, 153, 1);
        expect_ev(0, 155, 0);
        expect_ev(0, 157, 1);
        expect_ev(0, 159, 0);
        expect_ev(1, 51, 1);
        expect_ev(1, 102, 0);
        for (int t = 135, l = 1; t <= 160; t += 3, l = 1 - l) expect_ev(1, t, l);
        release_rst();
        run_to(60);
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b1;
        bus.code       = 8'd0;
        run_to(61);
        bus.code_valid = 1'b0;
        #1;
        check("pending_ch1_stop", 32'(pending), 32'd2);
        run_to(101);
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b0;
        bus.code       = 8'd1;
        run_to(102);
        bus.code_valid = 1'b0;
        #1;
        check("same_cycle_accept_pending", 32'(pending), 32'd1);
        check("outputs_after_102", 32'(dco_out), 32'd0);
        run_to(130);
        check("ch1_stays_low", 32'(dco_out[1]), 32'd0);
        check("ch0_still_pending", 32'(pending), 32'd1);
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b1;
        bus.code       = 8'd2;
        run_to(131);
        bus.code_valid = 1'b0;
        #1;
        check("pending_ch1_restart", 32'(pending), 32'd3);
        run_to(132);
        check("restart_applied", 32'(pending), 32'd1);
        check("restart_no_toggle", 32'(dco_out[1]), 32'd0);
        end_phase(160);

        // ---- Back-to-back requests on ch0; out-of-range channel ----
        do_reset();
        expect_ev(0, 51, 1);
        expect_ev(0, 55, 0);
        expect_ev(0, 63, 1);
        expect_ev(0, 71, 0);
        expect_ev(0, 79, 1);
        expect_ev(1, 51, 1);
        release_rst();
        run_to(10);
        bus.code_valid  = 1'b1;
        bus.code_ch     = 1'b0;
        bus.code        = 8'd3;
        bus3.code_valid = 1'b1;
        bus3.code_ch    = 2'd3;
        bus3.code       = 8'd5;
        #1;
        check("oor_ready", 32'(bus3.code_ready), 32'd1);
        run_to(11);
        bus3.code_valid = 1'b0;
        bus.code        = 8'd7;
        #1;
        check("oor_no_state", 32'(pend3), 32'd0);
        check("b2b_pending", 32'(pending), 32'd1);
        check("b2b_stall", 32'(bus.code_ready), 32'd0);
        run_to(30);
        check("b2b_still_stalled", 32'(bus.code_ready), 32'd0);
        run_to(51);
        check("b2b_ready_again", 32'(bus.code_ready), 32'd1);
        run_to(52);
        bus.code_valid = 1'b0;
        #1;
        check("b2b_second_pending", 32'(pending), 32'd1);
        end_phase(80);

`ifdef DCO_PHASE_SYNC_EN
        // ---- Phase sync with ch0 H=4, ch1 H=6 ----
        do_reset();
        expect_ev(0, 51, 1);
        expect_ev(0, 53, 0);
        expect_ev(0, 58, 1);
        expect_ev(0, 63, 0);
        expect_ev(0, 68, 1);
        expect_ev(0, 73, 0);
        expect_ev(1, 51, 1);
        expect_ev(1, 53, 0);
        expect_ev(1, 60, 1);
        expect_ev(1, 67, 0);
        expect_ev(1, 74, 1);
        bus.code_valid = 1'b1;
        bus.code_ch    = 1'b0;
        bus.code       = 8'd4;
        release_rst();
        run_to(1);
        bus.code_ch = 1'b1;
        bus.code    = 8'd6;
        run_to(2);
        bus.code_valid = 1'b0;
        run_to(52);
        sync = 1'b1;
        run_to(53);
        sync = 1'b0;
        #1;
        check("sync_outputs_low", 32'(dco_out), 32'd0);
        end_phase(75);
`endif

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
